// File: rtl/rx_deflush_fifo.sv
// rx_deflush_fifo: elastic FWFT buffer between the RX deflusher and consumer.
// Stores {error, data} words; reports fill level, almost-full and overflow.
`ifndef UNITWIDTH
`define UNITWIDTH 8
`endif
`ifndef LANENUMBER
`define LANENUMBER 4
`endif

module rx_deflush_fifo #(
  parameter int DATA_WIDTH  = `UNITWIDTH*`LANENUMBER,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_enable,
  input  logic [DATA_WIDTH-1:0] in_rxdata,
  input  logic                  in_rxdata_valid,
  input  logic                  in_rxdata_error,
  output logic [DATA_WIDTH-1:0] out_rxdata,
  output logic                  out_rxdata_valid,
  output logic                  out_rxdata_error,
  input  logic                  out_rxdata_ready,
  output logic                  in_afull,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic [7:0]            overflow_count,
  input  logic                  clr_overflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  wr_en;
  logic                  drop;

  assign push  = in_enable & in_rxdata_valid;
  assign pop   = out_rxdata_valid & out_rxdata_ready;
  assign full  = (fill_level == FULL_L);
  // a pop frees the slot the same cycle, so full+pop still accepts
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign out_rxdata_valid = (fill_level != '0);
  assign out_rxdata       = mem[rd_ptr][DATA_WIDTH-1:0];
  assign out_rxdata_error = mem[rd_ptr][DATA_WIDTH];
  assign in_afull         = (fill_level >= AFULL_L);

  always_ff @(posedge clk) begin
    if (wr_en && reset_n) begin
      mem[wr_ptr] <= {in_rxdata_error, in_rxdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   fill_level <= fill_level + (ADDR_WIDTH+1)'(1);
        2'b01:   fill_level <= fill_level - (ADDR_WIDTH+1)'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow       <= 1'b0;
      overflow_count <= 8'd0;
    end else if (drop) begin
      // a drop coincident with a clear restarts the count at one
      overflow <= 1'b1;
      if (clr_overflow) begin
        overflow_count <= 8'd1;
      end else if (overflow_count != 8'hff) begin
        overflow_count <= overflow_count + 8'd1;
      end
    end else if (clr_overflow) begin
      overflow       <= 1'b0;
      overflow_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_rx_deflush_fifo.sv
// tb_rx_deflush_fifo: directed-step bench for rx_deflush_fifo.
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_rx_deflush_fifo;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_enable;
  logic [DW-1:0] in_rxdata;
  logic          in_rxdata_valid;
  logic          in_rxdata_error;
  logic [DW-1:0] out_rxdata;
  logic          out_rxdata_valid;
  logic          out_rxdata_error;
  logic          out_rxdata_ready;
  logic          in_afull;
  logic [4:0]    fill_level;
  logic          overflow;
  logic [7:0]    overflow_count;
  logic          clr_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_deflush_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(4),
    .AFULL_LEVEL(12)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_enable(in_enable),
    .in_rxdata(in_rxdata),
    .in_rxdata_valid(in_rxdata_valid),
    .in_rxdata_error(in_rxdata_error),
    .out_rxdata(out_rxdata),
    .out_rxdata_valid(out_rxdata_valid),
    .out_rxdata_error(out_rxdata_error),
    .out_rxdata_ready(out_rxdata_ready),
    .in_afull(in_afull),
    .fill_level(fill_level),
    .overflow(overflow),
    .overflow_count(overflow_count),
    .clr_overflow(clr_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic e);
    in_enable       = 1'b1;
    in_rxdata_valid = 1'b1;
    in_rxdata       = d;
    in_rxdata_error = e;
    step();
  endtask

  task automatic idle();
    in_rxdata_valid = 1'b0;
    in_rxdata_error = 1'b0;
  endtask

  initial begin
    reset_n          = 1'b0;
    in_enable        = 1'b0;
    in_rxdata        = '0;
    in_rxdata_valid  = 1'b0;
    in_rxdata_error  = 1'b0;
    out_rxdata_ready = 1'b0;
    clr_overflow     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("rst_fill", fill_level, 0);
    chk("rst_valid", out_rxdata_valid, 0);
    chk("rst_afull", in_afull, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", overflow_count, 0);

    // 1: three words, then drain in order
    push(32'h11, 1'b0);
    chk("t1_latency_valid", out_rxdata_valid, 1);
    push(32'h22, 1'b1);
    push(32'h33, 1'b0);
    idle();
    chk("t1_fill", fill_level, 3);
    chk("t1_head", out_rxdata, 32'h11);
    chk("t1_head_err", out_rxdata_error, 0);
    out_rxdata_ready = 1'b1;
    chk("t1_d0", out_rxdata, 32'h11);
    chk("t1_e0", out_rxdata_error, 0);
    step();
    chk("t1_d1", out_rxdata, 32'h22);
    chk("t1_e1", out_rxdata_error, 1);
    step();
    chk("t1_d2", out_rxdata, 32'h33);
    chk("t1_e2", out_rxdata_error, 0);
    step();
    chk("t1_empty_valid", out_rxdata_valid, 0);
    chk("t1_empty_fill", fill_level, 0);
    step();
    chk("t1_ready_empty_fill", fill_level, 0);
    out_rxdata_ready = 1'b0;

    // 2: qualifiers
    in_enable = 1'b0;
    in_rxdata_valid = 1'b1;
    in_rxdata = 32'hdead;
    for (int i = 0; i < 5; i++) step();
    chk("t2_en0_fill", fill_level, 0);
    chk("t2_en0_valid", out_rxdata_valid, 0);
    in_enable = 1'b1;
    in_rxdata_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t2_v0_fill", fill_level, 0);
    chk("t2_v0_valid", out_rxdata_valid, 0);

    // 3: overfill by two
    for (int i = 0; i < 18; i++) begin
      push(DW'(i), 1'b0);
      chk("t3_fill", fill_level, (i + 1 > 16) ? 16 : i + 1);
      chk("t3_afull", in_afull, (i + 1 >= 12) ? 1 : 0);
    end
    idle();
    chk("t3_ovf", overflow, 1);
    chk("t3_cnt", overflow_count, 2);
    out_rxdata_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", out_rxdata, i);
      step();
    end
    out_rxdata_ready = 1'b0;
    chk("t3_drained", out_rxdata_valid, 0);
    chk("t3_ovf_held", overflow, 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t3_clr_ovf", overflow, 0);
    chk("t3_clr_cnt", overflow_count, 0);

    // 4: full with simultaneous push and pop across wrap
    for (int i = 0; i < 16; i++) push(DW'(100 + i), 1'b0);
    chk("t4_full", fill_level, 16);
    out_rxdata_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("t4_head", out_rxdata, 100 + i);
      push(DW'(116 + i), i[0]);
      chk("t4_fill", fill_level, 16);
    end
    idle();
    chk("t4_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t4_tail", out_rxdata, 140 + i);
      chk("t4_tail_err", out_rxdata_error, (i % 2 == 1) ? 1 : 0);
      step();
    end
    out_rxdata_ready = 1'b0;
    chk("t4_empty", out_rxdata_valid, 0);

    // 5: reset mid-operation
    for (int i = 0; i < 7; i++) push(DW'(200 + i), 1'b0);
    chk("t5_fill7", fill_level, 7);
    reset_n = 1'b0;
    push(32'h999, 1'b1);
    reset_n = 1'b1;
    idle();
    chk("t5_rst_fill", fill_level, 0);
    chk("t5_rst_valid", out_rxdata_valid, 0);
    chk("t5_rst_ovf", overflow, 0);
    push(32'h300, 1'b0);
    push(32'h301, 1'b1);
    idle();
    chk("t5_fill2", fill_level, 2);
    chk("t5_head0", out_rxdata, 32'h300);
    out_rxdata_ready = 1'b1;
    step();
    chk("t5_head1", out_rxdata, 32'h301);
    chk("t5_err1", out_rxdata_error, 1);
    step();
    out_rxdata_ready = 1'b0;
    chk("t5_empty", out_rxdata_valid, 0);

    // 6: saturating drop count, clear coincident with a drop
    for (int i = 0; i < 16; i++) push(DW'(i), 1'b0);
    for (int i = 0; i < 300; i++) push(32'hbad, 1'b0);
    chk("t6_sat_cnt", overflow_count, 255);
    chk("t6_sat_ovf", overflow, 1);
    chk("t6_sat_fill", fill_level, 16);
    chk("t6_head_kept", out_rxdata, 0);
    clr_overflow = 1'b1;
    push(32'hbad, 1'b0);
    clr_overflow = 1'b0;
    idle();
    chk("t6_clr_drop_ovf", overflow, 1);
    chk("t6_clr_drop_cnt", overflow_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_deflush_fifo.md
Name: rx_deflush_fifo

Overview:
- Receive-side elastic buffer placed directly downstream of the RX deflusher stage.
- Captures every word the deflusher marks valid, together with its error flag, into a DEPTH-entry FIFO.
- Presents the words to the RX consumer through a valid/ready handshake.
- Decouples the consumer's backpressure from the line rate, and reports fill level, almost-full and overflow status.

Parameters:
- DATA_WIDTH, default `UNITWIDTH*`LANENUMBER: width of one data word. Must equal the deflusher output width.
- ADDR_WIDTH, default 4: FIFO address width. DEPTH = 2**ADDR_WIDTH = 16 entries.
- AFULL_LEVEL, default 12: fill level at or above which in_afull asserts. Legal range 1..DEPTH.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- in_enable  input  1  write qualifier; words are captured only when high
- in_rxdata  input  DATA_WIDTH  word from the deflusher
- in_rxdata_valid  input  1  word valid from the deflusher
- in_rxdata_error  input  1  error flag travelling with the word
- out_rxdata  output  DATA_WIDTH  head-of-FIFO word
- out_rxdata_valid  output  1  FIFO not empty
- out_rxdata_error  output  1  error flag of the head word
- out_rxdata_ready  input  1  consumer accepts the head word
- in_afull  output  1  fill level >= AFULL_LEVEL
- fill_level  output  ADDR_WIDTH+1  current number of stored entries
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full
- overflow_count  output  8  number of dropped words, saturates at 255
- clr_overflow  input  1  clears overflow and overflow_count

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. While reset_n=0 at a clk edge:
  - wr_ptr, rd_ptr and fill_level go to 0.
  - out_rxdata_valid=0, in_afull=0, overflow=0, overflow_count=0.
  - out_rxdata and out_rxdata_error are don't-care while out_rxdata_valid=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all stored words on that edge; the consumer sees valid drop on the next cycle.
- Push: push = in_enable & in_rxdata_valid. Words with in_rxdata_valid=0 are never stored, whatever their data value.
- Pop: pop = out_rxdata_valid & out_rxdata_ready. Pop is independent of in_enable.
- Storage: each entry holds {error, data}. On accept, mem[wr_ptr] <= {in_rxdata_error, in_rxdata} and wr_ptr increments mod DEPTH.
- Read: out_rxdata/out_rxdata_error = mem[rd_ptr] (first-word-fall-through). On pop, rd_ptr increments mod DEPTH.
- Latency: a word pushed at edge N is visible with out_rxdata_valid=1 after edge N (one cycle), provided the FIFO was empty before.
- out_rxdata_valid = (fill_level != 0), registered through fill_level.
- fill_level update:
  - accepted push with no pop: +1
  - pop with no accepted push: -1
  - both: unchanged
- Full, push without pop: the word is dropped and not written; wr_ptr and fill_level are unchanged.
  - overflow <= 1.
  - overflow_count <= overflow_count+1, saturating at 255.
- Full, push with pop in the same cycle: the push is accepted, the head is popped, fill_level stays at DEPTH, no overflow.
- Empty, push: accepted. No pop is possible because valid=0 that cycle; the word is not bypassed.
- Ready while empty: out_rxdata_ready=1 with out_rxdata_valid=0 is ignored; no pointer change.
- in_afull is combinational from fill_level: (fill_level >= AFULL_LEVEL).
- clr_overflow=1 at an edge:
  - overflow <= 0 and overflow_count <= 0.
  - If an overflow drop occurs in the same cycle, the drop wins: overflow <= 1, overflow_count <= 1.
- Pointers are ADDR_WIDTH bits and wrap naturally. Full/empty are decided solely from fill_level (0 or DEPTH).
- Valid/ready handshake rule: once out_rxdata_valid=1, the head word and error flag hold stable until popped (or reset).
- Error flag: passed through unmodified per word. The block never drops or alters a word because of in_rxdata_error.

Test Plan:
1. Reset, then push 3 words 0x11, 0x22, 0x33 (error=0,1,0) with ready=0.
   -> fill_level=3, valid=1, head=0x11/err0.
   Then ready=1 for 3 cycles -> outputs 0x11/0, 0x22/1, 0x33/0 in order, then valid=0, fill_level=0.
2. in_enable=0 with in_rxdata_valid=1 for 5 cycles -> fill_level stays 0, valid stays 0.
   in_rxdata_valid=0 with in_enable=1 -> nothing stored.
3. ready=0, push 18 words 0..17 -> fill_level=16, in_afull=1 from fill 12 onward, overflow=1, overflow_count=2.
   Drain -> words 0..15 only.
   Pulse clr_overflow -> overflow=0, count=0.
4. Fill to 16, then push and ready=1 together for 40 cycles -> fill_level stays 16, no overflow.
   Output sequence is contiguous across pointer wrap.
5. Fill to 7, assert reset_n=0 for one edge with push active -> fill_level=0, valid=0 next cycle, no overflow.
   Post-reset pushes are output starting from the first new word.
6. Drive 300 consecutive drops while full -> overflow_count saturates at 255.
   clr_overflow coincident with a drop -> overflow=1, overflow_count=1.
